// File: rtl/z_run_logger.sv
// Measures runs of z high and queues {saturated, length} records for a valid/ready reader.
// Optional ZRUN_MINLEN_EN: discard unsaturated runs shorter than MIN_LEN.
module z_run_logger #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MIN_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_len,
    output logic             rd_sat,
    output logic             active,
    output logic             overflow
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned RW  = CNT_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] len_q, len_nx;
    logic             sat_q, sat_nx;
    logic             push_req;
    logic             keep_run;

    logic [RW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wptr, rptr, wptr_nx, rptr_nx;
    logic [RW-1:0]    rec, head_nx;
    logic             full, pop, do_push, drop;

`ifdef ZRUN_MINLEN_EN
    assign keep_run = sat_q || (len_q >= CNT_W'(MIN_LEN));
`else
    assign keep_run = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and run measurement
    always_comb begin
        state_nx = state;
        len_nx   = len_q;
        sat_nx   = sat_q;
        push_req = 1'b0;
        case (state)
            IDLE: begin
                if (z) begin
                    state_nx = RUN;
                    len_nx   = CNT_W'(1);
                    sat_nx   = 1'b0;
                end
            end
            RUN: begin
                if (z) begin
                    if (len_q != '1) len_nx = len_q + CNT_W'(1);
                    else             sat_nx = 1'b1;
                end else begin
                    state_nx = IDLE;
                    push_req = keep_run;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO control; the new head is computed ahead so outputs come straight from flops
    always_comb begin
        rec     = {sat_q, len_q};
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        pop     = rd_valid && rd_ready;
        do_push = push_req && (!full || pop);
        drop    = push_req && full && !pop;
        wptr_nx = wptr + PW'(do_push);
        rptr_nx = rptr + PW'(pop);
        if (do_push && (wptr == rptr_nx)) head_nx = rec;
        else                              head_nx = mem[rptr_nx[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            sat_q    <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
            rd_len   <= '0;
            rd_sat   <= 1'b0;
            active   <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            len_q    <= len_nx;
            sat_q    <= sat_nx;
            wptr     <= wptr_nx;
            rptr     <= rptr_nx;
            rd_valid <= (wptr_nx != rptr_nx);
            rd_sat   <= head_nx[CNT_W];
            rd_len   <= head_nx[CNT_W-1:0];
            // Stays high through the cycle after the terminating z=0 sample
            active   <= (state_nx == RUN) || (state == RUN);
            overflow <= overflow | drop;
            if (do_push) mem[wptr[AW-1:0]] <= rec;
        end
    end

endmodule
